// File: rtl/spi_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : spi_pkg                                                    |
// | Brief   : Shared frame widths, peripheral register map and FSM state |
// |           encoding for the SPI initiator and its bench.              |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
package spi_pkg;

  localparam int FRAME_W = 16;
  localparam int ADDR_W  = 7;
  localparam int DATA_W  = 8;

  // Register map of the on-chip SPI register peripheral
  localparam logic [ADDR_W-1:0] REG_EN_OUT_LO   = 7'h00;
  localparam logic [ADDR_W-1:0] REG_EN_OUT_HI   = 7'h01;
  localparam logic [ADDR_W-1:0] REG_PWM_MODE_LO = 7'h02;
  localparam logic [ADDR_W-1:0] REG_PWM_MODE_HI = 7'h03;
  localparam logic [ADDR_W-1:0] REG_PWM_DUTY    = 7'h04;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_SHIFT = 3'd2,
    ST_HOLD  = 3'd3,
    ST_GAP   = 3'd4
  } spi_state_e;

  // Frame layout on the wire, MSB first: {write, addr, data}
  function automatic logic [FRAME_W-1:0] build_frame(
    input logic              write,
    input logic [ADDR_W-1:0] addr,
    input logic [DATA_W-1:0] data
  );
    return {write, addr, data};
  endfunction

endpackage
`default_nettype wire

// File: rtl/spi_sclk_divider.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : spi_sclk_divider                                           |
// | Brief   : SCLK generator. Each level lasts CLK_DIV clk cycles; the   |
// |           rise/fall strobes are high in the cycle before SCLK        |
// |           actually changes, so users can update data on that edge.   |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
module spi_sclk_divider #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_en,
  output logic o_rise,
  output logic o_fall,
  output logic o_sclk
);

  localparam int c_cnt_w = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(CLK_DIV - 1);

  logic [c_cnt_w-1:0] r_cnt;
  logic               r_sclk;
  logic               w_wrap;

  assign w_wrap = i_en && (r_cnt == c_cnt_last);
  assign o_rise = w_wrap && !r_sclk;
  assign o_fall = w_wrap &&  r_sclk;
  assign o_sclk = r_sclk;

  // Half-period counter; disabling returns SCLK low and restarts the phase
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt  <= '0;
      r_sclk <= 1'b0;
    end else if (!i_en) begin
      r_cnt  <= '0;
      r_sclk <= 1'b0;
    end else if (w_wrap) begin
      r_cnt  <= '0;
      r_sclk <= ~r_sclk;
    end else begin
      r_cnt  <= r_cnt + c_cnt_w'(1);
    end
  end

endmodule
`default_nettype wire

// File: rtl/spi_controller.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : spi_controller                                             |
// | Brief   : SPI mode-0 initiator. Sends one 16-bit {write,addr,data}   |
// |           frame per accepted request, MSB first, on nCS/SCLK/COPI.   |
// |           All pad outputs come straight from flops.                  |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
module spi_controller
  import spi_pkg::*;
#(
  parameter int CLK_DIV  = 4,
  parameter int CS_SETUP = 2,
  parameter int CS_HOLD  = 2,
  parameter int IDLE_GAP = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_data,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic              aborted,
  output logic              nCS,
  output logic              SCLK,
  output logic              COPI
);

  // One shared phase counter serves SETUP, HOLD and GAP
  localparam int c_cnt_max =
    (CS_SETUP > CS_HOLD) ? ((CS_SETUP > IDLE_GAP) ? CS_SETUP : IDLE_GAP)
                         : ((CS_HOLD  > IDLE_GAP) ? CS_HOLD  : IDLE_GAP);
  localparam int c_cnt_w = $clog2(c_cnt_max + 1);

  localparam logic [c_cnt_w-1:0] c_setup_last = c_cnt_w'(CS_SETUP - 1);
  localparam logic [c_cnt_w-1:0] c_hold_last  = c_cnt_w'(CS_HOLD - 1);
  localparam logic [c_cnt_w-1:0] c_gap_last   = c_cnt_w'(IDLE_GAP - 1);
  localparam logic [4:0]         c_last_bit   = 5'(FRAME_W);

  spi_state_e          r_state,   w_state_d;
  logic [c_cnt_w-1:0]  r_cnt,     w_cnt_d;
  logic [4:0]          r_bit_cnt, w_bit_cnt_d;
  logic [FRAME_W-1:0]  r_shift,   w_shift_d;
  logic                r_copi,    w_copi_d;
  logic                r_ncs,     w_ncs_d;
  logic                r_done,    w_done_d;
  logic                r_aborted, w_aborted_d;

  logic w_div_en;
  logic w_rise;
  logic w_fall;
  logic w_sclk;

  // An abort stops SCLK on the very next edge, alongside the nCS release
  assign w_div_en = (r_state == ST_SHIFT) && !abort;

  spi_sclk_divider #(
    .CLK_DIV (CLK_DIV)
  ) u_sclk_div (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_en   (w_div_en),
    .o_rise (w_rise),
    .o_fall (w_fall),
    .o_sclk (w_sclk)
  );

  assign req_ready = (r_state == ST_IDLE);
  assign busy      = (r_state != ST_IDLE);
  assign done      = r_done;
  assign aborted   = r_aborted;
  assign nCS       = r_ncs;
  assign SCLK      = w_sclk;
  assign COPI      = r_copi;

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_bit_cnt <= '0;
      r_shift   <= '0;
      r_copi    <= 1'b0;
      r_ncs     <= 1'b1;
      r_done    <= 1'b0;
      r_aborted <= 1'b0;
    end else begin
      r_state   <= w_state_d;
      r_cnt     <= w_cnt_d;
      r_bit_cnt <= w_bit_cnt_d;
      r_shift   <= w_shift_d;
      r_copi    <= w_copi_d;
      r_ncs     <= w_ncs_d;
      r_done    <= w_done_d;
      r_aborted <= w_aborted_d;
    end
  end

  // Next-state and next-output logic of the frame sequencer
  always_comb begin
    w_state_d   = r_state;
    w_cnt_d     = r_cnt;
    w_bit_cnt_d = r_bit_cnt;
    w_shift_d   = r_shift;
    w_copi_d    = r_copi;
    w_ncs_d     = r_ncs;
    w_done_d    = 1'b0;
    w_aborted_d = 1'b0;

    case (r_state)
      // Accept takes priority over a coincident abort
      ST_IDLE: begin
        if (req_valid) begin
          w_state_d   = ST_SETUP;
          w_cnt_d     = '0;
          w_bit_cnt_d = '0;
          w_shift_d   = build_frame(req_write, req_addr, req_data);
          w_copi_d    = req_write;
          w_ncs_d     = 1'b0;
        end
      end

      // nCS stays high for IDLE_GAP cycles; abort is meaningless here
      ST_GAP: begin
        if (r_cnt == c_gap_last) begin
          w_state_d = ST_IDLE;
          w_cnt_d   = '0;
        end else begin
          w_cnt_d   = r_cnt + c_cnt_w'(1);
        end
      end

      default: begin
        if (abort) begin
          // Abort beats every in-frame transition, including HOLD's last cycle
          w_state_d   = ST_GAP;
          w_cnt_d     = '0;
          w_bit_cnt_d = '0;
          w_copi_d    = 1'b0;
          w_ncs_d     = 1'b1;
          w_aborted_d = 1'b1;
        end else begin
          case (r_state)
            ST_SETUP: begin
              if (r_cnt == c_setup_last) begin
                w_state_d = ST_SHIFT;
                w_cnt_d   = '0;
              end else begin
                w_cnt_d   = r_cnt + c_cnt_w'(1);
              end
            end

            ST_SHIFT: begin
              if (w_rise) begin
                w_bit_cnt_d = r_bit_cnt + 5'd1;
              end
              if (w_fall) begin
                if (r_bit_cnt == c_last_bit) begin
                  w_state_d = ST_HOLD;
                  w_cnt_d   = '0;
                  w_copi_d  = 1'b0;
                end else begin
                  w_shift_d = {r_shift[FRAME_W-2:0], 1'b0};
                  w_copi_d  = r_shift[FRAME_W-2];
                end
              end
            end

            ST_HOLD: begin
              if (r_cnt == c_hold_last) begin
                w_state_d = ST_GAP;
                w_cnt_d   = '0;
                w_ncs_d   = 1'b1;
                w_done_d  = 1'b1;
              end else begin
                w_cnt_d   = r_cnt + c_cnt_w'(1);
              end
            end

            // Unreachable encodings recover to a quiet IDLE
            default: begin
              w_state_d = ST_IDLE;
              w_cnt_d   = '0;
              w_copi_d  = 1'b0;
              w_ncs_d   = 1'b1;
            end
          endcase
        end
      end
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_spi_controller.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : tb_spi_controller                                          |
// | Brief   : Directed, table-driven bench for spi_controller with the   |
// |           default timing parameters.                                 |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
module tb_spi_controller;

  localparam int CLK_DIV  = 4;
  localparam int CS_SETUP = 2;
  localparam int CS_HOLD  = 2;
  localparam int IDLE_GAP = 4;

  logic       clk       = 1'b0;
  logic       rst_n     = 1'b0;
  logic       req_valid = 1'b0;
  logic       req_write = 1'b0;
  logic [6:0] req_addr  = 7'h00;
  logic [7:0] req_data  = 8'h00;
  logic       abort     = 1'b0;
  logic       req_ready;
  logic       busy;
  logic       done;
  logic       aborted;
  logic       nCS;
  logic       SCLK;
  logic       COPI;

  int n_cmp = 0;
  int n_bad = 0;

  spi_controller #(
    .CLK_DIV  (CLK_DIV),
    .CS_SETUP (CS_SETUP),
    .CS_HOLD  (CS_HOLD),
    .IDLE_GAP (IDLE_GAP)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_data  (req_data),
    .abort     (abort),
    .busy      (busy),
    .done      (done),
    .aborted   (aborted),
    .nCS       (nCS),
    .SCLK      (SCLK),
    .COPI      (COPI)
  );

  always #5 clk = ~clk;

  // One vector = one frame request plus everything expected from it.
  // Cycle k counts clock periods after the accepting edge (k=1 first).
  typedef struct {
    logic        w;
    logic [6:0]  a;
    logic [7:0]  d;
    int          abort_k;     // -1 none, 0 with accept, else driven for cycle k
    bit          scramble;    // randomise request inputs during the frame
    logic [15:0] exp_frame;
    int          exp_nrise;
    int          exp_ncs;     // cycles with nCS low
    int          exp_done_k;  // -1 = no done pulse
    int          exp_abort_k; // -1 = no aborted pulse
  } vec_t;

  vec_t vecs [8];

  task automatic check(input int id, input string name,
                       input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL v%0d.%s: got 0x%0h, expected 0x%0h", id, name, act, exp);
    end
  endtask

  task automatic do_frame(input int id, input vec_t v);
    logic [15:0] rx;
    logic [15:0] exp_rx;
    logic        prev_sclk;
    int k, nrise, ncs_low, ndone, nabort, done_k, abort_k, event_k, ready_k;
    int ready_bad, pad_bad;
    bit fin;
    rx = '0; prev_sclk = 1'b0; k = 0; nrise = 0; ncs_low = 0; ndone = 0;
    nabort = 0; done_k = -1; abort_k = -1; event_k = -1; ready_k = -1;
    ready_bad = 0; pad_bad = 0; fin = 1'b0;

    @(negedge clk);
    check(id, "ready_before", req_ready, 1);
    req_valid = 1'b1; req_write = v.w; req_addr = v.a; req_data = v.d;
    abort = (v.abort_k == 0);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    abort = 1'b0;

    while (!fin && k < 400) begin
      @(negedge clk);
      k++;
      abort = (k == v.abort_k);
      if (v.scramble) begin
        req_write = 1'($urandom);
        req_addr  = 7'($urandom);
        req_data  = 8'($urandom);
      end
      if (!nCS) ncs_low++;
      if (SCLK && !prev_sclk) begin
        rx = {rx[14:0], COPI};
        nrise++;
      end
      prev_sclk = SCLK;
      if (done) begin
        ndone++;
        done_k = k;
      end
      if (aborted) begin
        nabort++;
        abort_k = k;
        if (nCS !== 1'b1 || SCLK !== 1'b0 || COPI !== 1'b0) pad_bad++;
      end
      if (busy === req_ready) ready_bad++;
      if (event_k < 0 && (done || aborted)) event_k = k;
      else if (event_k < 0 && req_ready) ready_bad++;
      else if (event_k >= 0 && req_ready) begin
        ready_k = k;
        fin = 1'b1;
      end
    end
    abort = 1'b0;

    exp_rx = v.exp_frame >> (16 - v.exp_nrise);
    check(id, "finished", fin, 1);
    check(id, "copi_bits", rx, exp_rx);
    check(id, "nrise", nrise, v.exp_nrise);
    check(id, "ncs_low", ncs_low, v.exp_ncs);
    check(id, "ndone", ndone, (v.exp_done_k >= 0) ? 1 : 0);
    check(id, "done_k", done_k, v.exp_done_k);
    check(id, "naborted", nabort, (v.exp_abort_k >= 0) ? 1 : 0);
    check(id, "aborted_k", abort_k, v.exp_abort_k);
    check(id, "abort_pads", pad_bad, 0);
    check(id, "ready_busy", ready_bad, 0);
    check(id, "gap_len", ready_k - event_k, IDLE_GAP);
  endtask

  // Back-to-back frames with req_valid held: measures the nCS-high gap
  task automatic do_back_to_back();
    logic [15:0] rx0, rx1;
    logic        prev_sclk, prev_ncs;
    int k, fidx, nd, hi_between, gap_busy;
    rx0 = '0; rx1 = '0; prev_sclk = 1'b0; prev_ncs = 1'b1;
    k = 0; fidx = 0; nd = 0; hi_between = 0; gap_busy = 0;

    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_addr = 7'h00; req_data = 8'hA5;
    @(posedge clk);
    #1;
    req_addr = 7'h01; req_data = 8'h5A;

    while (nd < 2 && k < 600) begin
      @(negedge clk);
      k++;
      if (prev_ncs && !nCS) fidx++;
      if (!nCS && fidx == 2) req_valid = 1'b0;
      if (SCLK && !prev_sclk) begin
        if (fidx == 1) rx0 = {rx0[14:0], COPI};
        else           rx1 = {rx1[14:0], COPI};
      end
      if (done) nd++;
      if (nd == 1 && fidx == 1) begin
        if (nCS) hi_between++;
        if (!req_ready) gap_busy++;
      end
      prev_ncs  = nCS;
      prev_sclk = SCLK;
    end
    req_valid = 1'b0;

    check(10, "b2b_done_count", nd, 2);
    check(10, "b2b_frame0", rx0, 16'h80A5);
    check(10, "b2b_frame1", rx1, 16'h815A);
    // GAP lasts IDLE_GAP cycles; the IDLE accept cycle adds one more nCS-high cycle
    check(10, "b2b_gap_not_ready", gap_busy, IDLE_GAP);
    check(10, "b2b_ncs_high", hi_between, IDLE_GAP + 1);

    k = 0;
    while (!req_ready && k < 50) begin
      @(negedge clk);
      k++;
    end
    check(10, "b2b_back_idle", req_ready, 1);
  endtask

  // Global time bound
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{1'b1, 7'h04, 8'h80,  -1, 1'b0, 16'h8480, 16, 132, 133,  -1};
    vecs[1] = '{1'b0, 7'h02, 8'hFF,  -1, 1'b0, 16'h02FF, 16, 132, 133,  -1};
    vecs[2] = '{1'b1, 7'h7F, 8'h3C,  -1, 1'b0, 16'hFF3C, 16, 132, 133,  -1};
    vecs[3] = '{1'b1, 7'h03, 8'hC3,  -1, 1'b1, 16'h83C3, 16, 132, 133,  -1};
    vecs[4] = '{1'b1, 7'h00, 8'h01,   0, 1'b0, 16'h8001, 16, 132, 133,  -1};
    vecs[5] = '{1'b1, 7'h01, 8'h5A,  39, 1'b0, 16'h815A,  5,  39,  -1,  40};
    vecs[6] = '{1'b1, 7'h04, 8'h55, 132, 1'b0, 16'h8455, 16, 132,  -1, 133};
    vecs[7] = '{1'b1, 7'h02, 8'h0F,  -1, 1'b1, 16'h820F, 16, 132, 133,  -1};

    // Reset state
    repeat (3) @(negedge clk);
    check(0, "rst_ncs", nCS, 1);
    check(0, "rst_sclk", SCLK, 0);
    check(0, "rst_copi", COPI, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check(0, "rst_ready", req_ready, 1);
    check(0, "rst_busy", busy, 0);
    check(0, "rst_done", done, 0);
    check(0, "rst_aborted", aborted, 0);
    check(0, "rst_ncs_after", nCS, 1);

    for (int i = 0; i < 8; i++) begin
      do_frame(i + 1, vecs[i]);
    end

    do_back_to_back();

    // Asynchronous reset in the middle of SHIFT, while SCLK and COPI are high
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_addr = 7'h7F; req_data = 8'h00;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    repeat (64) @(negedge clk);
    check(11, "pre_rst_sclk", SCLK, 1);
    check(11, "pre_rst_ncs", nCS, 0);
    check(11, "pre_rst_copi", COPI, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check(11, "async_rst_ncs", nCS, 1);
    check(11, "async_rst_sclk", SCLK, 0);
    check(11, "async_rst_copi", COPI, 0);
    check(11, "async_rst_busy", busy, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check(11, "post_rst_ready", req_ready, 1);
    do_frame(12, vecs[0]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
